// File: rtl/video_daisy_frame_sync.sv
// video_daisy_frame_sync
//   Frame-alignment stage between the daisy-chain pixel stream and the
//   line-buffer VGA core. Tracks the x/y raster position, only lets pixels
//   through once a frame_start has been seen at (0,0), and re-locks when the
//   stream slips. Output side is a 2-entry registered skid buffer so src_rdy
//   is a plain flop.
//   Optional: define VIDEO_FRAME_SYNC_ERR_CNT_EN to add the saturating
//   misalignment counter on sync_err_cnt.
module video_daisy_frame_sync #(
    parameter int RGB_SIZE  = 12,
    parameter int HRES      = 640,
    parameter int VRES      = 480,
    parameter int ERR_WIDTH = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [RGB_SIZE:0]   src_data,
    input  logic                src_vld,
    output logic                src_rdy,
    output logic [RGB_SIZE:0]   line_buffer_data,
    output logic                line_buffer_vld,
    input  logic                line_buffer_rdy,
    output logic                sync_locked
`ifdef VIDEO_FRAME_SYNC_ERR_CNT_EN
    ,
    output logic [ERR_WIDTH-1:0] sync_err_cnt
`endif
);

    localparam int XW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int YW = (VRES > 1) ? $clog2(VRES) : 1;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [XW-1:0]     x, x_nxt;
    logic [YW-1:0]     y, y_nxt;
    logic              accept, emit, fs, expected, pass, err_evt;
    logic [RGB_SIZE:0] skid;
    logic [1:0]        cnt, cnt_nxt;

    assign accept   = src_vld && src_rdy;
    assign emit     = line_buffer_vld && line_buffer_rdy;
    assign fs       = src_data[RGB_SIZE];
    assign expected = (x == '0) && (y == '0);

    // Alignment decision for the pixel being accepted this cycle
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        pass      = 1'b0;
        err_evt   = 1'b0;
        if (accept) begin
            if (state == HUNT) begin
                if (fs) begin
                    pass      = 1'b1;
                    x_nxt     = XW'(1);
                    y_nxt     = '0;
                    state_nxt = LOCK;
                end
            end else if (fs == expected) begin
                pass = 1'b1;
                if (x == XW'(HRES - 1)) begin
                    x_nxt = '0;
                    y_nxt = (y == YW'(VRES - 1)) ? '0 : y + YW'(1);
                end else begin
                    x_nxt = x + XW'(1);
                end
            end else if (fs) begin
                // early frame start: restart the raster on this pixel
                pass    = 1'b1;
                err_evt = 1'b1;
                x_nxt   = XW'(1);
                y_nxt   = '0;
            end else begin
                // frame start missing where expected: drop and hunt again
                err_evt   = 1'b1;
                state_nxt = HUNT;
            end
        end
    end

    // Skid occupancy after this cycle's push/pop
    always_comb begin
        case ({pass, emit})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Raster position, lock state and lock flag
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state       <= HUNT;
            x           <= '0;
            y           <= '0;
            sync_locked <= 1'b0;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            sync_locked <= (state_nxt == LOCK);
        end
    end

    // Two-entry skid buffer: line_buffer_data is the head, skid the tail
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cnt              <= 2'd0;
            skid             <= '0;
            line_buffer_data <= '0;
            line_buffer_vld  <= 1'b0;
            src_rdy          <= 1'b0;
        end else begin
            cnt             <= cnt_nxt;
            line_buffer_vld <= (cnt_nxt != 2'd0);
            src_rdy         <= (cnt_nxt < 2'd2);
            if (emit && pass) begin
                if (cnt == 2'd2) begin
                    line_buffer_data <= skid;
                    skid             <= src_data;
                end else begin
                    line_buffer_data <= src_data;
                end
            end else if (emit) begin
                if (cnt == 2'd2) line_buffer_data <= skid;
            end else if (pass) begin
                if (cnt == 2'd0) line_buffer_data <= src_data;
                else             skid             <= src_data;
            end
        end
    end

`ifdef VIDEO_FRAME_SYNC_ERR_CNT_EN
    // Saturating misalignment counter, cleared only by reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst)                        sync_err_cnt <= '0;
        else if (err_evt && ~&sync_err_cnt)  sync_err_cnt <= sync_err_cnt + ERR_WIDTH'(1);
    end
`else
    logic [ERR_WIDTH-1:0] unused_err_evt;
    assign unused_err_evt = {ERR_WIDTH{err_evt}};
`endif

endmodule
